// File: rtl/fp_conv_pkg.sv
// Shared encodings for the float-to-integer converter: FSM states,
// rounding-mode codes and status-flag bit positions.
package fp_conv_pkg;

   typedef enum logic [2:0] {
      ST_GET_A  = 3'd0,
      ST_UNPACK = 3'd1,
      ST_SHIFT  = 3'd2,
      ST_ROUND  = 3'd3,
      ST_PUT_Z  = 3'd4
   } state_t;

   localparam logic [1:0] ROUND_RTZ = 2'b00;
   localparam logic [1:0] ROUND_RNE = 2'b01;
   localparam logic [1:0] ROUND_RUP = 2'b10;
   localparam logic [1:0] ROUND_RDN = 2'b11;

   localparam int FLAG_INVALID  = 2;
   localparam int FLAG_OVERFLOW = 1;
   localparam int FLAG_INEXACT  = 0;

endpackage

// File: rtl/fp_to_int_conv_round_sat.sv
// Combinational rounding increment, sign application and range saturation
// of an unsigned magnitude with guard/round/sticky bits.
module int_round_sat
   import fp_conv_pkg::*;
#(
   parameter int INT_W  = 64,
   parameter bit SIGNED = 1'b1
) (
   input  logic [INT_W-1:0] mag,
   input  logic             guard,
   input  logic             round_bit,
   input  logic             sticky,
   input  logic             sign,
   input  logic             big,
   input  logic             is_nan,
   input  logic             is_inf,
   input  logic [1:0]       round_mode,
   output logic [INT_W-1:0] z,
   output logic [2:0]       flags
);

   localparam logic [INT_W-1:0] MIN_MAG = {1'b1, {(INT_W-1){1'b0}}};
   localparam logic [INT_W-1:0] MAX_POS = {1'b0, {(INT_W-1){1'b1}}};

   logic             inexact;
   logic             inc;
   logic [INT_W:0]   sum;
   logic [INT_W-1:0] rmag;
   logic             too_big;

   always_comb begin
      inexact = guard | round_bit | sticky;
      case (round_mode)
         ROUND_RTZ: inc = 1'b0;
         ROUND_RNE: inc = guard & (round_bit | sticky | mag[0]);
         ROUND_RUP: inc = ~sign & inexact;
         default:   inc = sign & inexact;
      endcase
      sum     = {1'b0, mag} + {{INT_W{1'b0}}, inc};
      rmag    = sum[INT_W-1:0];
      // a carry out of the increment means the magnitude reached 2^INT_W
      too_big = big | sum[INT_W];

      z     = '0;
      flags = '0;
      if (is_nan) begin
         flags[FLAG_INVALID] = 1'b1;
      end else if (SIGNED) begin
         if (!sign && (too_big || rmag[INT_W-1])) begin
            z                    = MAX_POS;
            flags[FLAG_OVERFLOW] = 1'b1;
         end else if (sign && (too_big || rmag > MIN_MAG)) begin
            z                    = MIN_MAG;
            flags[FLAG_OVERFLOW] = 1'b1;
         end else begin
            z                   = sign ? -rmag : rmag;
            flags[FLAG_INEXACT] = inexact;
         end
      end else begin
         if (sign) begin
            if (is_inf) begin
               flags[FLAG_OVERFLOW] = 1'b1;
            end else if (too_big || rmag != '0) begin
               flags[FLAG_INVALID] = 1'b1;
            end else begin
               flags[FLAG_INEXACT] = inexact;
            end
         end else if (too_big) begin
            z                    = '1;
            flags[FLAG_OVERFLOW] = 1'b1;
         end else begin
            z                   = rmag;
            flags[FLAG_INEXACT] = inexact;
         end
      end
   end

endmodule

// File: rtl/fp_to_int_conv.sv
// IEEE-754 float to integer converter with stb/ack handshakes, runtime
// rounding mode, saturation and {invalid, overflow, inexact} flags.
module fp_to_int_conv
   import fp_conv_pkg::*;
#(
   parameter int EXP_W  = 11,
   parameter int MAN_W  = 52,
   parameter int INT_W  = 64,
   parameter bit SIGNED = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [EXP_W+MAN_W:0]   input_a,
   input  logic                   input_a_stb,
   output logic                   input_a_ack,
   input  logic [1:0]             round_mode,
   output logic [INT_W-1:0]       output_z,
   output logic                   output_z_stb,
   input  logic                   output_z_ack,
   output logic [2:0]             output_flags
);

   localparam int FP_W = 1 + EXP_W + MAN_W;
   localparam int EW   = EXP_W + 2;
   // integer bits, then guard, round and MAN_W+1 sticky bits
   localparam int TW   = INT_W + MAN_W + 3;

   localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] E_ONE = EW'(1);
   localparam logic signed [EW-1:0] E_INT = EW'(INT_W);
   localparam logic signed [EW-1:0] E_LOW = EW'(-3);
   localparam logic signed [EW-1:0] E_OFS = EW'(3);

   state_t                 state_q, state_d;
   logic                   a_ack_q, a_ack_d;
   logic [FP_W-1:0]        a_q, a_d;
   logic [1:0]             rm_q, rm_d;
   logic                   sign_q, sign_d;
   logic signed [EW-1:0]   e_q, e_d;
   logic [MAN_W:0]         sig_q, sig_d;
   logic                   nan_q, nan_d;
   logic                   inf_q, inf_d;
   logic [INT_W-1:0]       mag_q, mag_d;
   logic                   guard_q, guard_d;
   logic                   rnd_q, rnd_d;
   logic                   sticky_q, sticky_d;
   logic                   big_q, big_d;
   logic [INT_W-1:0]       z_q, z_d;
   logic                   z_stb_q, z_stb_d;
   logic [2:0]             flags_q, flags_d;

   logic [EXP_W-1:0]       exp_f;
   logic [MAN_W-1:0]       man_f;
   logic                   exp_max;
   logic                   exp_zero;
   logic [EW-1:0]          sh_amt;
   logic [TW-1:0]          shifted;
   logic                   e_small;
   logic                   e_over;
   logic [INT_W-1:0]       rs_z;
   logic [2:0]             rs_flags;

   // unpack and alignment views of the captured operand
   always_comb begin
      exp_f    = a_q[MAN_W +: EXP_W];
      man_f    = a_q[MAN_W-1:0];
      exp_max  = &exp_f;
      exp_zero = ~|exp_f;
      sh_amt   = e_q + E_OFS;
      shifted  = {{(TW-MAN_W-1){1'b0}}, sig_q} << sh_amt;
      e_small  = e_q < E_LOW;
      e_over   = (e_q >= E_INT) | inf_q;
   end

   int_round_sat #(
      .INT_W  (INT_W),
      .SIGNED (SIGNED)
   ) u_round_sat (
      .mag        (mag_q),
      .guard      (guard_q),
      .round_bit  (rnd_q),
      .sticky     (sticky_q),
      .sign       (sign_q),
      .big        (big_q),
      .is_nan     (nan_q),
      .is_inf     (inf_q),
      .round_mode (rm_q),
      .z          (rs_z),
      .flags      (rs_flags)
   );

   always_comb begin
      state_d  = state_q;
      a_ack_d  = a_ack_q;
      a_d      = a_q;
      rm_d     = rm_q;
      sign_d   = sign_q;
      e_d      = e_q;
      sig_d    = sig_q;
      nan_d    = nan_q;
      inf_d    = inf_q;
      mag_d    = mag_q;
      guard_d  = guard_q;
      rnd_d    = rnd_q;
      sticky_d = sticky_q;
      big_d    = big_q;
      z_d      = z_q;
      z_stb_d  = z_stb_q;
      flags_d  = flags_q;

      case (state_q)
         ST_GET_A: begin
            if (a_ack_q && input_a_stb) begin
               a_d     = input_a;
               rm_d    = round_mode;
               a_ack_d = 1'b0;
               state_d = ST_UNPACK;
            end else begin
               a_ack_d = 1'b1;
            end
         end
         ST_UNPACK: begin
            sign_d  = a_q[FP_W-1];
            e_d     = exp_zero ? (E_ONE - BIAS) : ($signed({2'b00, exp_f}) - BIAS);
            sig_d   = {~exp_zero, man_f};
            nan_d   = exp_max && (man_f != '0);
            inf_d   = exp_max && (man_f == '0);
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            // below 2^-3 only stickiness matters; at or above 2^INT_W it cannot fit
            if (e_over) begin
               mag_d    = '0;
               guard_d  = 1'b0;
               rnd_d    = 1'b0;
               sticky_d = 1'b0;
            end else if (e_small) begin
               mag_d    = '0;
               guard_d  = 1'b0;
               rnd_d    = 1'b0;
               sticky_d = |sig_q;
            end else begin
               mag_d    = shifted[TW-1 -: INT_W];
               guard_d  = shifted[MAN_W+2];
               rnd_d    = shifted[MAN_W+1];
               sticky_d = |shifted[MAN_W:0];
            end
            big_d   = e_over;
            state_d = ST_ROUND;
         end
         ST_ROUND: begin
            z_d     = rs_z;
            flags_d = rs_flags;
            z_stb_d = 1'b1;
            state_d = ST_PUT_Z;
         end
         ST_PUT_Z: begin
            if (output_z_ack) begin
               z_stb_d = 1'b0;
               state_d = ST_GET_A;
            end
         end
         default: begin
            state_d = ST_GET_A;
            a_ack_d = 1'b0;
            z_stb_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_GET_A;
         a_ack_q  <= 1'b0;
         a_q      <= '0;
         rm_q     <= ROUND_RTZ;
         sign_q   <= 1'b0;
         e_q      <= '0;
         sig_q    <= '0;
         nan_q    <= 1'b0;
         inf_q    <= 1'b0;
         mag_q    <= '0;
         guard_q  <= 1'b0;
         rnd_q    <= 1'b0;
         sticky_q <= 1'b0;
         big_q    <= 1'b0;
         z_q      <= '0;
         z_stb_q  <= 1'b0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         a_ack_q  <= a_ack_d;
         a_q      <= a_d;
         rm_q     <= rm_d;
         sign_q   <= sign_d;
         e_q      <= e_d;
         sig_q    <= sig_d;
         nan_q    <= nan_d;
         inf_q    <= inf_d;
         mag_q    <= mag_d;
         guard_q  <= guard_d;
         rnd_q    <= rnd_d;
         sticky_q <= sticky_d;
         big_q    <= big_d;
         z_q      <= z_d;
         z_stb_q  <= z_stb_d;
         flags_q  <= flags_d;
      end
   end

   assign input_a_ack  = a_ack_q;
   assign output_z     = z_q;
   assign output_z_stb = z_stb_q;
   assign output_flags = flags_q;

endmodule

// File: tb/tb_fp_to_int_conv.sv
// Self-checking bench: a double/signed/64-bit instance and a
// single/unsigned/32-bit instance checked against an exact arithmetic model.
module tb_fp_to_int_conv;

   logic        clk = 1'b0;
   logic        rst;
   int          n_cmp = 0;
   int          n_bad = 0;

   logic [63:0] a1, z1;
   logic        a1_stb, a1_ack, z1_stb, z1_ack;
   logic [1:0]  rm1;
   logic [2:0]  fl1;

   logic [31:0] a2, z2;
   logic        a2_stb, a2_ack, z2_stb, z2_ack;
   logic [1:0]  rm2;
   logic [2:0]  fl2;

   always #5 clk = ~clk;

   fp_to_int_conv #(.EXP_W(11), .MAN_W(52), .INT_W(64), .SIGNED(1'b1)) u_dbl (
      .clk(clk), .rst(rst),
      .input_a(a1), .input_a_stb(a1_stb), .input_a_ack(a1_ack), .round_mode(rm1),
      .output_z(z1), .output_z_stb(z1_stb), .output_z_ack(z1_ack), .output_flags(fl1)
   );

   fp_to_int_conv #(.EXP_W(8), .MAN_W(23), .INT_W(32), .SIGNED(1'b0)) u_sgl (
      .clk(clk), .rst(rst),
      .input_a(a2), .input_a_stb(a2_stb), .input_a_ack(a2_ack), .round_mode(rm2),
      .output_z(z2), .output_z_stb(z2_stb), .output_z_ack(z2_ack), .output_flags(fl2)
   );

   // Exact model: value = sig * 2^(e-mw), rounding decided by comparing the
   // discarded remainder against one half.
   function automatic void ref_conv(input logic [63:0] bits, input int ew, input int mw,
                                    input int iw, input bit sgn, input logic [1:0] rm,
                                    output logic [63:0] z, output logic [2:0] fl);
      logic [127:0] man, sig, ip, rem, half, mag, mask, lim;
      int expv, emax, bias, e, rs;
      bit neg, inexact, above, tie, up;
      neg  = bits[ew+mw];
      emax = (1 << ew) - 1;
      bias = (1 << (ew - 1)) - 1;
      expv = int'((bits >> mw) & 64'(emax));
      man  = 128'(bits & ((64'd1 << mw) - 64'd1));
      mask = (128'd1 << iw) - 128'd1;
      lim  = (128'd1 << (iw - 1)) - 128'd1;
      ip = '0; rem = '0; half = '0; inexact = 0; above = 0; tie = 0; up = 0;
      z = '0; fl = '0;
      if (expv == emax) begin
         if (man != 0) begin
            fl = 3'b100;
         end else begin
            fl = 3'b010;
            if (!neg) z = 64'(sgn ? lim : mask);
            else      z = 64'(sgn ? lim + 128'd1 : 128'd0);
         end
      end else begin
         sig = (expv != 0) ? (man | (128'd1 << mw)) : man;
         e   = (expv != 0) ? expv - bias : 1 - bias;
         if (e > 70) begin
            ip = 128'd1 << 100;
         end else if (e >= mw) begin
            ip = sig << (e - mw);
         end else begin
            rs = mw - e;
            if (rs >= 120) begin
               inexact = (sig != 0);
            end else begin
               ip      = sig >> rs;
               rem     = sig & ((128'd1 << rs) - 128'd1);
               half    = 128'd1 << (rs - 1);
               inexact = (rem != 0);
               above   = (rem > half);
               tie     = (rem == half);
            end
         end
         case (rm)
            2'b00:   up = 0;
            2'b01:   up = above || (tie && ip[0]);
            2'b10:   up = !neg && inexact;
            default: up = neg && inexact;
         endcase
         mag = ip + 128'(up);
         if (sgn) begin
            if (!neg && mag > lim) begin
               z = 64'(lim); fl = 3'b010;
            end else if (neg && mag > lim + 128'd1) begin
               z = 64'(lim + 128'd1); fl = 3'b010;
            end else begin
               z  = 64'(neg ? ((~mag + 128'd1) & mask) : mag);
               fl = {2'b00, inexact};
            end
         end else begin
            if (neg) begin
               fl = (mag != 0) ? 3'b100 : {2'b00, inexact};
            end else if (mag > mask) begin
               z = 64'(mask); fl = 3'b010;
            end else begin
               z = 64'(mag); fl = {2'b00, inexact};
            end
         end
      end
   endfunction

   function automatic logic [63:0] rnd_dbl();
      logic [51:0] m;
      logic [10:0] ex;
      int c;
      m = 52'({$urandom, $urandom});
      c = $urandom_range(15, 0);
      case (c)
         0:       begin ex = '1; m[0] = 1'b1; end
         1:       begin ex = '1; m = '0; end
         2:       begin ex = '0; m = '0; end
         3:       ex = 11'($urandom_range(1020, 0));
         4, 5:    begin ex = 11'($urandom_range(1089, 1020)); m[39:0] = '0; end
         default: ex = 11'($urandom_range(1089, 1020));
      endcase
      return {1'($urandom), ex, m};
   endfunction

   function automatic logic [31:0] rnd_sgl();
      logic [22:0] m;
      logic [7:0]  ex;
      int c;
      m = 23'($urandom);
      c = $urandom_range(11, 0);
      case (c)
         0:       begin ex = '1; m[0] = 1'b1; end
         1:       begin ex = '1; m = '0; end
         2:       begin ex = '0; m = '0; end
         3, 4:    begin ex = 8'($urandom_range(163, 124)); m[15:0] = '0; end
         default: ex = 8'($urandom_range(163, 120));
      endcase
      return {1'($urandom), ex, m};
   endfunction

   task automatic send1(input logic [63:0] bits, input logic [1:0] rm);
      bit ok;
      ok = 0;
      a1 = bits; rm1 = rm; a1_stb = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (a1_ack) begin ok = 1; break; end
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL send1_timeout: input_a_ack never seen, required 1");
      end
      @(posedge clk); #1;
      a1_stb = 1'b0; a1 = {$urandom, $urandom}; rm1 = 2'($urandom);
   endtask

   task automatic wait_z1(output int lat);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (z1_stb) begin lat = i; break; end
      end
      if (lat == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_z1_timeout: output_z_stb never seen, required 1");
      end
   endtask

   task automatic take_z1();
      z1_ack = 1'b1;
      @(posedge clk); #1;
      z1_ack = 1'b0;
   endtask

   task automatic send2(input logic [31:0] bits, input logic [1:0] rm);
      bit ok;
      ok = 0;
      a2 = bits; rm2 = rm; a2_stb = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (a2_ack) begin ok = 1; break; end
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL send2_timeout: input_a_ack never seen, required 1");
      end
      @(posedge clk); #1;
      a2_stb = 1'b0; a2 = $urandom; rm2 = 2'($urandom);
   endtask

   task automatic wait_z2(output int lat);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (z2_stb) begin lat = i; break; end
      end
      if (lat == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_z2_timeout: output_z_stb never seen, required 1");
      end
      z2_ack = 1'b1;
      @(posedge clk); #1;
      z2_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (z1_stb !== 1'b0 || a1_ack !== 1'b0) begin n_bad++;
         $display("FAIL reset_dbl_hs: stb=%b ack=%b required 0 0", z1_stb, a1_ack); end
      n_cmp++; if (z1 !== 64'd0 || fl1 !== 3'b000) begin n_bad++;
         $display("FAIL reset_dbl_out: z=%h flags=%b required 0 000", z1, fl1); end
      n_cmp++; if (z2_stb !== 1'b0 || a2_ack !== 1'b0) begin n_bad++;
         $display("FAIL reset_sgl_hs: stb=%b ack=%b required 0 0", z2_stb, a2_ack); end
      n_cmp++; if (z2 !== 32'd0 || fl2 !== 3'b000) begin n_bad++;
         $display("FAIL reset_sgl_out: z=%h flags=%b required 0 000", z2, fl2); end
      @(posedge clk); #1;
      n_cmp++; if (a1_ack !== 1'b0) begin n_bad++;
         $display("FAIL reset_hold_ack: ack=%b required 0", a1_ack); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (a1_ack !== 1'b1 || a2_ack !== 1'b1) begin n_bad++;
         $display("FAIL reset_release_ack: ack=%b%b required 11", a1_ack, a2_ack); end
   endtask

   task automatic test_directed();
      logic [63:0] vin [13];
      logic [1:0]  vrm [13];
      logic [63:0] vz  [13];
      logic [2:0]  vfl [13];
      int lat;
      vin = '{64'h4059000000000000, 64'h4004000000000000, 64'h400C000000000000,
              64'hC004000000000000, 64'h4415AF1D78B58C40, 64'hC3E0000000000000,
              64'h7FF8000000000000, 64'h43DFFFFFFFFFFFFF, 64'hFFF0000000000000,
              64'h8000000000000000, 64'h3FE8000000000000, 64'hBFE8000000000000,
              64'h43E0000000000000};
      vrm = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00,
              2'b10, 2'b01, 2'b11, 2'b00};
      vz  = '{64'h64, 64'h2, 64'h4, 64'hFFFFFFFFFFFFFFFE, 64'h7FFFFFFFFFFFFFFF,
              64'h8000000000000000, 64'h0, 64'h7FFFFFFFFFFFFC00, 64'h8000000000000000,
              64'h0, 64'h1, 64'hFFFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF};
      vfl = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b010, 3'b000, 3'b100, 3'b000,
              3'b010, 3'b000, 3'b001, 3'b001, 3'b010};
      for (int i = 0; i < 13; i++) begin
         send1(vin[i], vrm[i]);
         wait_z1(lat);
         $display("dir in=%h rm=%0d z=%h flags=%b lat=%0d", vin[i], vrm[i], z1, fl1, lat);
         n_cmp++; if (lat !== 3) begin n_bad++;
            $display("FAIL dir%0d_latency: got %0d required 3", i, lat); end
         n_cmp++; if (z1 !== vz[i]) begin n_bad++;
            $display("FAIL dir%0d_z: got %h required %h", i, z1, vz[i]); end
         n_cmp++; if (fl1 !== vfl[i]) begin n_bad++;
            $display("FAIL dir%0d_flags: got %b required %b", i, fl1, vfl[i]); end
         take_z1();
      end
   endtask

   task automatic test_random();
      logic [63:0] x, ez;
      logic [2:0]  ef;
      logic [1:0]  rm;
      int lat;
      for (int i = 0; i < 150; i++) begin
         x  = rnd_dbl();
         rm = 2'($urandom);
         ref_conv(x, 11, 52, 64, 1'b1, rm, ez, ef);
         send1(x, rm);
         wait_z1(lat);
         $display("rnd in=%h rm=%0d z=%h flags=%b", x, rm, z1, fl1);
         n_cmp++; if (z1 !== ez || fl1 !== ef) begin n_bad++;
            $display("FAIL rnd%0d in=%h rm=%0d: got z=%h flags=%b required z=%h flags=%b",
                     i, x, rm, z1, fl1, ez, ef); end
         take_z1();
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] x, ez, z0;
      logic [2:0]  ef, f0;
      int lat;
      x = 64'hC0934A4587E7C06E;
      ref_conv(x, 11, 52, 64, 1'b1, 2'b01, ez, ef);
      send1(x, 2'b01);
      a1_stb = 1'b1;
      wait_z1(lat);
      z0 = z1; f0 = fl1;
      $display("bp in=%h z=%h flags=%b", x, z1, fl1);
      n_cmp++; if (z0 !== ez || f0 !== ef) begin n_bad++;
         $display("FAIL bp_value: got z=%h flags=%b required z=%h flags=%b", z0, f0, ez, ef); end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_cmp++; if (z1 !== z0 || fl1 !== f0 || z1_stb !== 1'b1 || a1_ack !== 1'b0) begin n_bad++;
            $display("FAIL bp_hold%0d: z=%h flags=%b stb=%b ack=%b required z=%h flags=%b stb=1 ack=0",
                     i, z1, fl1, z1_stb, a1_ack, z0, f0); end
      end
      a1_stb = 1'b0;
      z1_ack = 1'b1;
      @(posedge clk); #1;
      z1_ack = 1'b0;
      n_cmp++; if (z1_stb !== 1'b0 || a1_ack !== 1'b0) begin n_bad++;
         $display("FAIL bp_ack_edge: stb=%b ack=%b required 0 0", z1_stb, a1_ack); end
      @(posedge clk); #1;
      n_cmp++; if (a1_ack !== 1'b1) begin n_bad++;
         $display("FAIL bp_ack_return: ack=%b required 1", a1_ack); end
   endtask

   task automatic test_async_reset();
      logic [63:0] y, ez;
      logic [2:0]  ef;
      int lat;
      send1(64'h40FE240C9FBE76C9, 2'b00);
      @(posedge clk); #1;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      n_cmp++; if (z1_stb !== 1'b0 || a1_ack !== 1'b0 || z1 !== 64'd0 || fl1 !== 3'b000) begin n_bad++;
         $display("FAIL arst_immediate: stb=%b ack=%b z=%h flags=%b required 0 0 0 000",
                  z1_stb, a1_ack, z1, fl1); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if (a1_ack !== 1'b1) begin n_bad++;
         $display("FAIL arst_ack_return: ack=%b required 1", a1_ack); end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_cmp++; if (z1_stb !== 1'b0) begin n_bad++;
            $display("FAIL arst_stale%0d: stb=%b required 0", i, z1_stb); end
      end
      y = 64'hC05EDD2F1A9FBE77;
      ref_conv(y, 11, 52, 64, 1'b1, 2'b11, ez, ef);
      send1(y, 2'b11);
      wait_z1(lat);
      $display("arst in=%h z=%h flags=%b", y, z1, fl1);
      n_cmp++; if (lat !== 3 || z1 !== ez || fl1 !== ef) begin n_bad++;
         $display("FAIL arst_next: lat=%0d z=%h flags=%b required lat=3 z=%h flags=%b",
                  lat, z1, fl1, ez, ef); end
      take_z1();
   endtask

   task automatic test_unsigned();
      logic [31:0] vin [3];
      logic [1:0]  vrm [3];
      logic [31:0] vz  [3];
      logic [2:0]  vfl [3];
      logic [31:0] x;
      logic [63:0] ez;
      logic [2:0]  ef;
      logic [1:0]  rm;
      int lat;
      vin = '{32'hBF800000, 32'h4F800000, 32'hBE99999A};
      vrm = '{2'b01, 2'b00, 2'b00};
      vz  = '{32'h0, 32'hFFFFFFFF, 32'h0};
      vfl = '{3'b100, 3'b010, 3'b001};
      for (int i = 0; i < 3; i++) begin
         send2(vin[i], vrm[i]);
         wait_z2(lat);
         $display("sgl in=%h rm=%0d z=%h flags=%b", vin[i], vrm[i], z2, fl2);
         n_cmp++; if (lat !== 3 || z2 !== vz[i] || fl2 !== vfl[i]) begin n_bad++;
            $display("FAIL sgl_dir%0d: lat=%0d z=%h flags=%b required lat=3 z=%h flags=%b",
                     i, lat, z2, fl2, vz[i], vfl[i]); end
      end
      for (int i = 0; i < 60; i++) begin
         x  = rnd_sgl();
         rm = 2'($urandom);
         ref_conv({32'd0, x}, 8, 23, 32, 1'b0, rm, ez, ef);
         send2(x, rm);
         wait_z2(lat);
         $display("sgl rnd in=%h rm=%0d z=%h flags=%b", x, rm, z2, fl2);
         n_cmp++; if (z2 !== ez[31:0] || fl2 !== ef) begin n_bad++;
            $display("FAIL sgl_rnd%0d in=%h rm=%0d: got z=%h flags=%b required z=%h flags=%b",
                     i, x, rm, z2, fl2, ez[31:0], ef); end
      end
   endtask

   initial begin
      rst = 1'b1;
      a1 = '0; a1_stb = 1'b0; rm1 = 2'b00; z1_ack = 1'b0;
      a2 = '0; a2_stb = 1'b0; rm2 = 2'b00; z2_ack = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_async_reset();
      test_unsigned();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
